dram_bank_rsp_1r1w_rl2_a721: RTL and testbench
==============================================

// Module: dram_bank_rsp_1r1w_rl2_a721
// PURPOSE
//  Responder (memory end) for one t1 bank port of the 1r1w rl2 a721 algorithm: accepts
//  read/write/refresh from the algo mux and returns fixed-latency read data with fwrd/serr/derr/padr.
//  One instance per bank in the IP bench and formal harness replaces the physical DRAM macro.
//  Injects ECC errors on request. Flags refresh starvation and access/refresh conflicts.
// PARAMETERS
//  WIDTH      32    data width per row
//  NUMVROW    1024  rows in the bank
//  BITVROW    10    row address width
//  BITPADR    10    padr width; row address zero-extended or truncated to fit
//  DRAM_DELAY 2     read latency in cycles; legal range 1..8
//  REFRESH    0     1 = enforce refresh interval checking
//  REFFREQ    16    max cycles allowed between refrB pulses when REFRESH=1
// PORTS
//  clk           in   1        clock; all state on rising edge
//  rst           in   1        asynchronous reset, active-high
//  readA         in   1        read request
//  writeA        in   1        write request
//  addrA         in   BITVROW  row address for read or write
//  dinA          in   WIDTH    write data
//  refrB         in   1        refresh request
//  err_inj_en    in   1        arm error injection, sampled at read issue
//  err_inj_adr   in   BITVROW  row that receives the injected error
//  err_inj_kind  in   2        01 = single-bit error, 10 = double-bit error, else none
//  doutA         out  WIDTH    read data, valid DRAM_DELAY cycles after issue
//  fwrdA         out  1        returned row was written in the cycle before the read issued
//  serrA         out  1        corrected single-bit error on this return
//  derrA         out  1        uncorrectable double-bit error on this return
//  padrA         out  BITPADR  row of an erroring read; 0 otherwise
//  conflict_err  out  1        one-cycle pulse on an illegal command combination
//  refr_starve_err out 1       sticky; REFFREQ cycles passed without refrB
// BEHAVIOUR
//  Reset: all outputs 0; read pipeline flushed; written-row bitmap cleared; refresh counter 0.
//   In-flight reads at reset are discarded and never returned.
//  Storage: NUMVROW x WIDTH array (not reset) plus NUMVROW-bit written bitmap (reset).
//   A read of a row never written returns 0.
//  Command priority per cycle: refrB > writeA > readA.
//   - refrB with readA or writeA: conflict_err=1 next cycle; the access is dropped (no write, no return).
//   - readA with writeA (no refrB): conflict_err=1 next cycle; the write is performed; the read is dropped.
//  Write: array[addrA] <= dinA at the edge; bitmap bit set. Write data is visible to a read issued next cycle.
//  Read issued at edge T: data captured from the array at T and returned at T+DRAM_DELAY through a
//   DRAM_DELAY-deep shift pipeline (valid, data, addr, fwrd, err kind).
//   Cycles with no return: doutA, fwrdA, serrA, derrA, padrA are all 0.
//   Back-to-back reads return back-to-back; no bubbles and no reordering.
//  fwrdA=1 on a return when writeA to the same addrA occurred at edge T-1.
//  Injection: at read issue with err_inj_en & addrA==err_inj_adr:
//   - kind 01: data returned uncorrupted, serrA=1, padrA=addr.
//   - kind 10: data bits [1:0] inverted, derrA=1, padrA=addr.
//   The stored array content is never modified by injection.
//  Refresh check, REFRESH=1 only:
//   - Counter increments each cycle and clears on refrB.
//   - When the count reaches REFFREQ without refrB, refr_starve_err sets and holds until rst.
//   - Counter saturates at REFFREQ.
//   REFRESH=0: counter held at 0; refr_starve_err stays 0; refrB still takes priority in command handling.
//  Width rule: padrA = addrA zero-extended to BITPADR, or the low bits if BITPADR<BITVROW.
// TESTING
//  1. write row 5 = 0xDEADBEEF, then read row 5 two cycles later
//     -> doutA=0xDEADBEEF exactly 2 cycles after the read; fwrd/serr/derr=0.
//  2. write row 7 = 0x1 at T, read row 7 at T+1 -> doutA=0x1, fwrdA=1 at T+1+DRAM_DELAY.
//  3. err_inj_kind=10, adr=3, row 3=0xF0 -> doutA=0xF3, derrA=1, padrA=3;
//     kind=01 -> doutA=0xF0, serrA=1.
//  4. readA and writeA at once on row 9 (din=0xAA) -> conflict_err pulse, no return;
//     a later read returns 0xAA.
//  5. REFRESH=1, REFFREQ=16, no refrB for 16 cycles -> refr_starve_err=1, held until rst.
//     refrB every 10 cycles -> stays 0.
//  6. Reads at T and T+1, rst asserted at T+1 -> no return data; all outputs 0;
//     a read of row 5 after reset returns 0.

Source files
------------

// File: rtl/dram_bank_rsp_1r1w_rl2_a721.sv
// Behavioural DRAM bank responder: fixed-latency reads with write-forward flag,
// on-demand ECC error injection, and conflict / refresh-starvation monitors.
module dram_bank_rsp_1r1w_rl2_a721 #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUMVROW    = 1024,
    parameter int unsigned BITVROW    = 10,
    parameter int unsigned BITPADR    = 10,
    parameter int unsigned DRAM_DELAY = 2,
    parameter int unsigned REFRESH    = 0,
    parameter int unsigned REFFREQ    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               readA,
    input  logic               writeA,
    input  logic [BITVROW-1:0] addrA,
    input  logic [WIDTH-1:0]   dinA,
    input  logic               refrB,
    input  logic               err_inj_en,
    input  logic [BITVROW-1:0] err_inj_adr,
    input  logic [1:0]         err_inj_kind,
    output logic [WIDTH-1:0]   doutA,
    output logic               fwrdA,
    output logic               serrA,
    output logic               derrA,
    output logic [BITPADR-1:0] padrA,
    output logic               conflict_err,
    output logic               refr_starve_err
);

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_SBE  = 2'b01,
        ERR_DBE  = 2'b10
    } err_kind_e;

    localparam int unsigned LAST = DRAM_DELAY - 1;

    logic [WIDTH-1:0]   r_mem [NUMVROW];
    logic [NUMVROW-1:0] r_wbm;

    logic               w_wr;
    logic               w_rd;
    logic               w_conf;
    err_kind_e          w_kind;
    logic [WIDTH-1:0]   w_rdata;
    logic               w_fwrd;

    logic               r_lwv;
    logic [BITVROW-1:0] r_lwa;
    logic               r_conf;

    logic               r_pv [DRAM_DELAY];
    logic [WIDTH-1:0]   r_pd [DRAM_DELAY];
    logic [BITPADR-1:0] r_pa [DRAM_DELAY];
    logic               r_pf [DRAM_DELAY];
    err_kind_e          r_pk [DRAM_DELAY];

    // Priority refrB > writeA > readA; any overlap is flagged as a conflict.
    always_comb begin
        w_wr   = writeA & ~refrB;
        w_rd   = readA & ~writeA & ~refrB;
        w_conf = (refrB & (readA | writeA)) | (readA & writeA);
    end

    always_comb begin
        w_kind = ERR_NONE;
        if (err_inj_en && (addrA == err_inj_adr)) begin
            case (err_inj_kind)
                2'b01:   w_kind = ERR_SBE;
                2'b10:   w_kind = ERR_DBE;
                default: w_kind = ERR_NONE;
            endcase
        end
    end

    always_comb begin
        w_rdata = r_wbm[addrA] ? r_mem[addrA] : '0;
        if (w_kind == ERR_DBE) begin
            w_rdata[1:0] = ~w_rdata[1:0];
        end
        w_fwrd = r_lwv && (r_lwa == addrA);
    end

    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_mem[addrA] <= dinA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbm  <= '0;
            r_lwv  <= 1'b0;
            r_lwa  <= '0;
            r_conf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wbm[addrA] <= 1'b1;
            end
            r_lwv  <= w_wr;
            r_lwa  <= addrA;
            r_conf <= w_conf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DRAM_DELAY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
                r_pa[i] <= '0;
                r_pf[i] <= 1'b0;
                r_pk[i] <= ERR_NONE;
            end
        end else begin
            r_pv[0] <= w_rd;
            r_pd[0] <= w_rd ? w_rdata : '0;
            r_pa[0] <= (w_rd && (w_kind != ERR_NONE)) ? BITPADR'(addrA) : '0;
            r_pf[0] <= w_rd & w_fwrd;
            r_pk[0] <= w_rd ? w_kind : ERR_NONE;
            for (int unsigned i = 1; i < DRAM_DELAY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pf[i] <= r_pf[i-1];
                r_pk[i] <= r_pk[i-1];
            end
        end
    end

    always_comb begin
        doutA        = '0;
        fwrdA        = 1'b0;
        serrA        = 1'b0;
        derrA        = 1'b0;
        padrA        = '0;
        conflict_err = r_conf;
        if (r_pv[LAST]) begin
            doutA = r_pd[LAST];
            fwrdA = r_pf[LAST];
            serrA = (r_pk[LAST] == ERR_SBE);
            derrA = (r_pk[LAST] == ERR_DBE);
            padrA = r_pa[LAST];
        end
    end

    // Starvation latches on the REFFREQ-th consecutive cycle without refrB.
    if (REFRESH != 0) begin : g_refr
        localparam int unsigned CW = $clog2(REFFREQ + 1);
        localparam logic [CW-1:0] CNT_MAX = CW'(REFFREQ);
        logic [CW-1:0] r_cnt;
        logic          r_starve;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt    <= '0;
                r_starve <= 1'b0;
            end else if (refrB) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CNT_MAX - CW'(1)) begin
                    r_starve <= 1'b1;
                end
            end
        end

        assign refr_starve_err = r_starve;
    end else begin : g_norefr
        assign refr_starve_err = 1'b0;
    end

endmodule

// File: tb/tb_dram_bank_rsp_1r1w_rl2_a721.sv
// Bench for dram_bank_rsp_1r1w_rl2_a721: directed vector table, reset and refresh
// sequences, then random traffic against a cycle-indexed return-schedule model.
module tb_dram_bank_rsp_1r1w_rl2_a721;

    localparam int W  = 32;
    localparam int NR = 1024;
    localparam int D  = 2;
    localparam int RF = 16;
    localparam int NT = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          readA = 1'b0;
    logic          writeA = 1'b0;
    logic [9:0]    addrA = '0;
    logic [W-1:0]  dinA = '0;
    logic          refrB = 1'b0;
    logic          err_inj_en = 1'b0;
    logic [9:0]    err_inj_adr = '0;
    logic [1:0]    err_inj_kind = '0;
    logic [W-1:0]  doutA;
    logic          fwrdA;
    logic          serrA;
    logic          derrA;
    logic [9:0]    padrA;
    logic          conflict_err;
    logic          refr_starve_err;

    always #5 clk = ~clk;

    dram_bank_rsp_1r1w_rl2_a721 #(
        .WIDTH(W), .NUMVROW(NR), .BITVROW(10), .BITPADR(10),
        .DRAM_DELAY(D), .REFRESH(1), .REFFREQ(RF)
    ) dut (
        .clk(clk), .rst(rst), .readA(readA), .writeA(writeA), .addrA(addrA),
        .dinA(dinA), .refrB(refrB), .err_inj_en(err_inj_en),
        .err_inj_adr(err_inj_adr), .err_inj_kind(err_inj_kind),
        .doutA(doutA), .fwrdA(fwrdA), .serrA(serrA), .derrA(derrA),
        .padrA(padrA), .conflict_err(conflict_err),
        .refr_starve_err(refr_starve_err)
    );

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          f, s, e;
        logic [9:0]  p;
    } ret_t;

    typedef struct {
        bit          rd, wr, rf;
        logic [9:0]  adr;
        logic [31:0] din;
        bit          ie;
        logic [9:0]  ia;
        logic [1:0]  ik;
        logic [31:0] ed;
        bit          ef, es, ee;
        logic [9:0]  ep;
        bit          ec;
    } vec_t;

    ret_t        slot [16];
    ret_t        exp_now;
    logic [31:0] m_mem [NR];
    bit          m_wbm [NR];
    bit          m_lwv;
    logic [9:0]  m_lwa;
    bit          m_conf;
    int          m_cnt;
    bit          m_starve;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    vec_t        tbl [NT];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) slot[i].v = 0;
        for (int i = 0; i < NR; i++) m_wbm[i] = 0;
        exp_now.v = 0;
        m_lwv = 0;
        m_lwa = '0;
        m_conf = 0;
        m_cnt = 0;
        m_starve = 0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input bit rf, input logic [9:0] adr,
                              input logic [31:0] din, input bit ie, input logic [9:0] ia,
                              input logic [1:0] ik);
        bit   do_wr;
        bit   do_rd;
        ret_t r;
        int   k;
        m_conf = (rf && (rd || wr)) || (rd && wr);
        do_wr = wr && !rf;
        do_rd = rd && !wr && !rf;
        if (do_rd) begin
            r.v = 1;
            r.d = m_wbm[adr] ? m_mem[adr] : 32'h0;
            r.f = m_lwv && (m_lwa == adr);
            k = (ie && ia == adr) ? int'(ik) : 0;
            r.s = (k == 1);
            r.e = (k == 2);
            if (r.e) r.d = r.d ^ 32'h3;
            r.p = (r.s || r.e) ? adr : 10'h0;
            slot[(cyc + D - 1) % 16] = r;
        end
        m_lwv = do_wr;
        m_lwa = adr;
        if (do_wr) begin
            m_mem[adr] = din;
            m_wbm[adr] = 1;
        end
        if (rf) m_cnt = 0;
        else if (m_cnt < RF) m_cnt++;
        if (m_cnt >= RF) m_starve = 1;
        exp_now = slot[cyc % 16];
        slot[cyc % 16].v = 0;
    endtask

    task automatic cmp_model();
        chk("doutA", doutA, exp_now.v ? exp_now.d : 32'h0);
        chk("fwrdA", 32'(fwrdA), 32'(exp_now.v && exp_now.f));
        chk("serrA", 32'(serrA), 32'(exp_now.v && exp_now.s));
        chk("derrA", 32'(derrA), 32'(exp_now.v && exp_now.e));
        chk("padrA", 32'(padrA), exp_now.v ? 32'(exp_now.p) : 32'h0);
        chk("conflict_err", 32'(conflict_err), 32'(m_conf));
        chk("refr_starve_err", 32'(refr_starve_err), 32'(m_starve));
    endtask

    task automatic apply(input bit rd, input bit wr, input bit rf, input logic [9:0] adr,
                         input logic [31:0] din, input bit ie, input logic [9:0] ia,
                         input logic [1:0] ik);
        readA = rd; writeA = wr; refrB = rf; addrA = adr; dinA = din;
        err_inj_en = ie; err_inj_adr = ia; err_inj_kind = ik;
        @(posedge clk);
        cyc++;
        model_edge(rd, wr, rf, adr, din, ie, ia, ik);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 10'd0, 32'h0, 0, 10'd0, 2'd0);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset();
        rst = 1'b1;
        writeA = 0; refrB = 0; err_inj_en = 0;
        #2;
        model_clear();
        cmp_model();
        chk("rst_async_dout", doutA, 32'h0);
        @(posedge clk);
        cyc++;
        #1;
        cmp_model();
        readA = 0;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(bit rd, bit wr, bit rf, int adr, logic [31:0] din, bit ie,
                                int ia, int ik, logic [31:0] ed, bit ef, bit es, bit ee,
                                int ep, bit ec);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rf = rf; v.adr = 10'(adr); v.din = din;
        v.ie = ie; v.ia = 10'(ia); v.ik = 2'(ik);
        v.ed = ed; v.ef = ef; v.es = es; v.ee = ee; v.ep = 10'(ep); v.ec = ec;
        return v;
    endfunction

    bit          r_rd, r_wr, r_rf, r_ie;
    logic [9:0]  r_adr, r_ia;
    logic [31:0] r_din;
    logic [1:0]  r_ik;

    initial begin
        // rd wr rf adr din | ie ia ik | exp: dout fwrd serr derr padr conflict
        tbl[0]  = mk(0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 5, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 7, 32'h1,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 7, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 3, 32'hF0,       0, 0, 0, 32'h1,        1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 3, 32'h0,        1, 3, 2, 32'h0,        0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 3, 32'h0,        1, 3, 1, 32'hF3,       0, 0, 1, 3, 0);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hF0,       0, 1, 0, 3, 0);
        tbl[11] = mk(1, 1, 0, 9, 32'hAA,       0, 0, 0, 32'h0,        0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 9, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hAA,       0, 0, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 3, 32'h0,        1, 4, 2, 32'h0,        0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 1, 5, 32'h0,        0, 0, 0, 32'hF0,       0, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tbl[19] = mk(1, 0, 0, 5, 32'h0,        1, 5, 3, 32'h0,        0, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);

        #1;
        do_reset();

        for (int i = 0; i < NT; i++) begin
            apply(tbl[i].rd, tbl[i].wr, tbl[i].rf, tbl[i].adr, tbl[i].din,
                  tbl[i].ie, tbl[i].ia, tbl[i].ik);
            chk($sformatf("tbl%0d_dout", i), doutA, tbl[i].ed);
            chk($sformatf("tbl%0d_fwrd", i), 32'(fwrdA), 32'(tbl[i].ef));
            chk($sformatf("tbl%0d_serr", i), 32'(serrA), 32'(tbl[i].es));
            chk($sformatf("tbl%0d_derr", i), 32'(derrA), 32'(tbl[i].ee));
            chk($sformatf("tbl%0d_padr", i), 32'(padrA), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d_conf", i), 32'(conflict_err), 32'(tbl[i].ec));
            cmp_model();
        end

        // In-flight reads discarded by reset; bitmap cleared so row 5 reads back 0.
        apply(0, 1, 1'b0, 10'd5, 32'h12345678, 0, 10'd0, 2'd0); cmp_model();
        idle(); cmp_model();
        apply(1, 0, 0, 10'd5, 32'h0, 0, 10'd0, 2'd0); cmp_model();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_rst_dout", doutA, 32'h0);
            cmp_model();
        end
        apply(1, 0, 0, 10'd5, 32'h0, 0, 10'd0, 2'd0); cmp_model();
        idle();
        chk("post_rst_read5", doutA, 32'h0);
        cmp_model();

        // Refresh starvation: sets on the 16th cycle without refrB, sticky until reset.
        do_reset();
        for (int i = 1; i <= 22; i++) begin
            idle();
            chk("starve_seq", 32'(refr_starve_err), (i >= RF) ? 32'h1 : 32'h0);
            cmp_model();
        end
        apply(0, 0, 1, 10'd0, 32'h0, 0, 10'd0, 2'd0);
        chk("starve_sticky", 32'(refr_starve_err), 32'h1);
        cmp_model();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            apply(0, 0, (i % 10) == 9, 10'd0, 32'h0, 0, 10'd0, 2'd0);
            chk("starve_refr10", 32'(refr_starve_err), 32'h0);
            cmp_model();
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            r_rd  = ($urandom_range(0, 99) < 45);
            r_wr  = ($urandom_range(0, 99) < 35);
            r_rf  = ($urandom_range(0, 99) < 8);
            r_adr = 10'($urandom_range(0, 15));
            r_din = $urandom;
            r_ie  = ($urandom_range(0, 3) == 0);
            r_ia  = 10'($urandom_range(0, 15));
            r_ik  = 2'($urandom_range(0, 3));
            apply(r_rd, r_wr, r_rf, r_adr, r_din, r_ie, r_ia, r_ik);
            cmp_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
